missed_dose_alert: RTL

- Downstream consumer of the medication box controller (medicine_machine).
- Watches its per-compartment shouldEat/notify outputs and counts consecutive missed doses per compartment.
- Raises sticky caregiver alerts, drives a patterned buzzer, and queues missed-dose event records in a small FIFO for the display/uplink stage.

---
 rtl/missed_dose_alert_if.sv | 8 +
 rtl/missed_dose_alert.sv | 97 +++++++++
 2 files changed

// File: rtl/missed_dose_alert_if.sv
// missed_dose_alert_if: missed-dose event record stream towards the display/uplink stage.
interface missed_dose_alert_if #(parameter int CNT_W = 3);
    logic             evt_valid;
    logic             evt_ready;
    logic [CNT_W+1:0] evt_data;
    modport master (output evt_valid, evt_data, input evt_ready);
    modport slave  (input evt_valid, evt_data, output evt_ready);
endinterface

// File: rtl/missed_dose_alert.sv
// missed_dose_alert: per-compartment missed-dose counting, caregiver alerts, patterned buzzer and event FIFO.
module missed_dose_alert #(
    parameter int MISS_LIMIT = 3,
    parameter int CNT_W      = 3,
    parameter int BUZZ_ON    = 2,
    parameter int BUZZ_OFF   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 should_eat,
    input  logic [3:0]                 notify,
    input  logic [3:0]                 ack,
    input  logic [3:0]                 clr_alert,
    output logic [3:0]                 caregiver_alert,
    output logic                       buzzer,
    output logic                       evt_overflow,
    missed_dose_alert_if.master        evt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PMAX = BUZZ_ON > BUZZ_OFF ? BUZZ_ON : BUZZ_OFF;
    localparam int BW = $clog2(PMAX + 1);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(MISS_LIMIT);
    typedef enum logic [1:0] {IDLE, ON, OFF, SOLID} state_t;
    logic [3:0]       prev_notify, ev, pend, pend_nxt, alert_nxt;
    logic [CNT_W-1:0] miss_cnt [4];
    logic [CNT_W-1:0] cnt_nxt [4];
    logic [CNT_W+1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [1:0]       sel;
    logic             push, pop, merge;
    state_t           state, state_nxt;
    logic [BW-1:0]    ph, ph_nxt;
    assign evt.evt_valid = count != '0;
    assign evt.evt_data  = evt.evt_valid ? mem[rd_ptr] : '0;
    always_comb begin
        ev = notify & ~prev_notify;
        sel = 2'd0;
        for (int i = 3; i >= 0; i--) if (pend[i]) sel = 2'(i);
        push = |pend && count < FULL;
        pop = evt.evt_valid && evt.evt_ready;
        for (int i = 0; i < 4; i++) begin
            // ack clears first, so a same-cycle event restarts the count at one
            cnt_nxt[i] = ack[i] ? CNT_W'(ev[i]) : (ev[i] && miss_cnt[i] != '1) ? miss_cnt[i] + 1'b1 : miss_cnt[i];
            alert_nxt[i] = cnt_nxt[i] >= LIM || (caregiver_alert[i] && !clr_alert[i]);
            pend_nxt[i] = ev[i] || (pend[i] && !(push && sel == 2'(i)));
        end
        merge = |(ev & pend & ~(4'(push) << sel));
    end
    always_comb begin
        state_nxt = state;
        ph_nxt = ph;
        if (|caregiver_alert) state_nxt = SOLID;
        else if (state == IDLE || state == SOLID) begin
            state_nxt = |should_eat ? ON : IDLE;
            ph_nxt = '0;
        end else if (should_eat == '0) state_nxt = IDLE;
        else if (state == ON && ph == BW'(BUZZ_ON - 1)) begin
            state_nxt = OFF;
            ph_nxt = '0;
        end else if (state == OFF && ph == BW'(BUZZ_OFF - 1)) begin
            state_nxt = ON;
            ph_nxt = '0;
        end else ph_nxt = ph + 1'b1;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            prev_notify <= '0;
            pend <= '0;
            caregiver_alert <= '0;
            evt_overflow <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            state <= IDLE;
            ph <= '0;
            buzzer <= 1'b0;
            for (int i = 0; i < 4; i++) miss_cnt[i] <= '0;
        end else begin
            prev_notify <= notify;
            pend <= pend_nxt;
            caregiver_alert <= alert_nxt;
            evt_overflow <= evt_overflow | merge;
            for (int i = 0; i < 4; i++) miss_cnt[i] <= cnt_nxt[i];
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            state <= state_nxt;
            ph <= ph_nxt;
            buzzer <= state_nxt == ON || state_nxt == SOLID;
        end
    // pushed record carries the registered count, i.e. the value after the event's update
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {sel, miss_cnt[sel]};
endmodule
